// File: rtl/match_ctrl_pkg.sv
// Shared match definitions: state and winner encodings, default widths.
package match_ctrl_pkg;

   localparam int unsigned SCORE_W = 4;
   localparam int unsigned POS_W   = 10;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_PLAY        = 2'd1,
      ST_POINT_PAUSE = 2'd2,
      ST_MATCH_OVER  = 2'd3
   } match_state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2
   } winner_e;

   function automatic logic is_player(input logic [1:0] w);
      return (w == WIN_P1) || (w == WIN_P2);
   endfunction

endpackage

// File: rtl/match_ctrl_snapshot.sv
// frame_snapshot: captures six coordinates together on valid_i so consumers
// never see a torn frame; snap_valid_o pulses the cycle after capture.
module frame_snapshot #(
   parameter int unsigned POS_W = match_ctrl_pkg::POS_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [POS_W-1:0] p1_x_i,
   input  logic [POS_W-1:0] p1_y_i,
   input  logic [POS_W-1:0] p2_x_i,
   input  logic [POS_W-1:0] p2_y_i,
   input  logic [POS_W-1:0] ball_x_i,
   input  logic [POS_W-1:0] ball_y_i,
   output logic [POS_W-1:0] p1_x_o,
   output logic [POS_W-1:0] p1_y_o,
   output logic [POS_W-1:0] p2_x_o,
   output logic [POS_W-1:0] p2_y_o,
   output logic [POS_W-1:0] ball_x_o,
   output logic [POS_W-1:0] ball_y_o,
   output logic             snap_valid_o
);

   logic [POS_W-1:0] p1_x_q, p1_y_q, p2_x_q, p2_y_q, ball_x_q, ball_y_q;
   logic             snap_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_x_q       <= '0;
         p1_y_q       <= '0;
         p2_x_q       <= '0;
         p2_y_q       <= '0;
         ball_x_q     <= '0;
         ball_y_q     <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         snap_valid_q <= valid_i;
         if (valid_i) begin
            p1_x_q   <= p1_x_i;
            p1_y_q   <= p1_y_i;
            p2_x_q   <= p2_x_i;
            p2_y_q   <= p2_y_i;
            ball_x_q <= ball_x_i;
            ball_y_q <= ball_y_i;
         end
      end
   end

   assign p1_x_o       = p1_x_q;
   assign p1_y_o       = p1_y_q;
   assign p2_x_o       = p2_x_q;
   assign p2_y_o       = p2_y_q;
   assign ball_x_o     = ball_x_q;
   assign ball_y_o     = ball_y_q;
   assign snap_valid_o = snap_valid_q;

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: frame gating, scoring, point pause and match-over sequencing
// around the physics engine, plus a per-frame coordinate snapshot.
module match_ctrl
   import match_ctrl_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned PAUSE_FRAMES = 90,
   parameter int unsigned SCORE_W      = match_ctrl_pkg::SCORE_W,
   parameter int unsigned POS_W        = match_ctrl_pkg::POS_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start_btn,
   output logic               phys_en,
   input  logic               phys_valid,
   input  logic               phys_game_over,
   input  logic [1:0]         phys_winner,
   input  logic [POS_W-1:0]   p1_x_in,
   input  logic [POS_W-1:0]   p1_y_in,
   input  logic [POS_W-1:0]   p2_x_in,
   input  logic [POS_W-1:0]   p2_y_in,
   input  logic [POS_W-1:0]   ball_x_in,
   input  logic [POS_W-1:0]   ball_y_in,
   output logic [POS_W-1:0]   p1_x,
   output logic [POS_W-1:0]   p1_y,
   output logic [POS_W-1:0]   p2_x,
   output logic [POS_W-1:0]   p2_y,
   output logic [POS_W-1:0]   ball_x,
   output logic [POS_W-1:0]   ball_y,
   output logic               snap_valid,
   output logic               ctrl_enable,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [1:0]         match_state,
   output logic [1:0]         match_winner
);

   localparam int unsigned CNT_W = (PAUSE_FRAMES < 2) ? 1 : $clog2(PAUSE_FRAMES + 1);
   localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_FRAMES);

   match_state_e       state_q, state_d;
   logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d, new_score;
   logic [1:0]         winner_q, winner_d;
   logic [CNT_W-1:0]   pause_q, pause_d;
   logic               go_seen_q, start_q;
   logic               phys_en_q, phys_en_d, ctrl_en_q, ctrl_en_d;
   logic               start_rise, pt;

   assign start_rise = start_btn & ~start_q;
   // go_seen masks the game_over level that persists while the engine is gated
   assign pt = phys_valid & phys_game_over & ~go_seen_q & is_player(phys_winner);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         p1_score_q <= '0;
         p2_score_q <= '0;
         winner_q   <= '0;
         pause_q    <= '0;
         go_seen_q  <= 1'b0;
         start_q    <= 1'b0;
         phys_en_q  <= 1'b0;
         ctrl_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         p1_score_q <= p1_score_d;
         p2_score_q <= p2_score_d;
         winner_q   <= winner_d;
         pause_q    <= pause_d;
         start_q    <= start_btn;
         phys_en_q  <= phys_en_d;
         ctrl_en_q  <= ctrl_en_d;
         if (phys_valid) go_seen_q <= phys_game_over;
      end
   end

   always_comb begin
      state_d    = state_q;
      p1_score_d = p1_score_q;
      p2_score_d = p2_score_q;
      winner_d   = winner_q;
      pause_d    = pause_q;
      new_score  = '0;
      case (state_q)
         ST_IDLE, ST_MATCH_OVER: begin
            if (start_rise) begin
               state_d    = ST_PLAY;
               p1_score_d = '0;
               p2_score_d = '0;
               winner_d   = WIN_NONE;
            end
         end
         ST_PLAY: begin
            if (pt) begin
               if (phys_winner == WIN_P1) begin
                  if (p1_score_q < WIN_S) p1_score_d = p1_score_q + 1'b1;
                  new_score = p1_score_d;
               end else begin
                  if (p2_score_q < WIN_S) p2_score_d = p2_score_q + 1'b1;
                  new_score = p2_score_d;
               end
               if (new_score == WIN_S) begin
                  state_d  = ST_MATCH_OVER;
                  winner_d = phys_winner;
               end else begin
                  state_d = ST_POINT_PAUSE;
                  pause_d = PAUSE_LOAD;
               end
            end
         end
         ST_POINT_PAUSE: begin
            // a count of 0 only occurs with PAUSE_FRAMES=0 and releases on the first tick
            if (frame_tick) begin
               if (pause_q != '0) pause_d = pause_q - 1'b1;
               if (pause_q <= CNT_W'(1)) state_d = ST_PLAY;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      phys_en_d = frame_tick & (state_q == ST_PLAY);
      ctrl_en_d = (state_d == ST_PLAY);
   end

   assign phys_en      = phys_en_q;
   assign ctrl_enable  = ctrl_en_q;
   assign p1_score     = p1_score_q;
   assign p2_score     = p2_score_q;
   assign match_state  = state_q;
   assign match_winner = winner_q;

   frame_snapshot #(.POS_W(POS_W)) u_snap (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (phys_valid),
      .p1_x_i       (p1_x_in),
      .p1_y_i       (p1_y_in),
      .p2_x_i       (p2_x_in),
      .p2_y_i       (p2_y_in),
      .ball_x_i     (ball_x_in),
      .ball_y_i     (ball_y_in),
      .p1_x_o       (p1_x),
      .p1_y_o       (p1_y),
      .p2_x_o       (p2_x),
      .p2_y_o       (p2_y),
      .ball_x_o     (ball_x),
      .ball_y_o     (ball_y),
      .snap_valid_o (snap_valid)
   );

endmodule
